// File: rtl/mem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mem_responder: multi-channel read/write request responder over one         |
// | single-port array, round-robin arbitration, fixed response latency.         |
// | Optional MEM_RESP_STATS_EN adds read_count/write_count grant counters.      |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int CHANNELS  = 4,
    parameter int LATENCY   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           read_valid,
    input  logic [CHANNELS*ADDR_BITS-1:0] read_address,
    output logic [CHANNELS-1:0]           read_ready,
    output logic [CHANNELS*DATA_BITS-1:0] read_data,
    input  logic [CHANNELS-1:0]           write_valid,
    input  logic [CHANNELS*ADDR_BITS-1:0] write_address,
    input  logic [CHANNELS*DATA_BITS-1:0] write_data,
    output logic [CHANNELS-1:0]           write_ready
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0]                   read_count,
    output logic [31:0]                   write_count
`endif
);

    localparam int         REQS      = 2 * CHANNELS;
    localparam int         PTR_W     = $clog2(REQS);
    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } req_state_t;

    logic [REQS-1:0]               req_valid;
    logic [REQS-1:0]               req_elig;
    logic [REQS-1:0]               req_ready;
    logic                          gnt_vld;
    logic [PTR_W-1:0]              gnt_idx;
    logic [PTR_W-1:0]              ptr_q;
    logic [PTR_W-1:0]              ptr_d;
    logic [ADDR_BITS-1:0]          gnt_addr;
    logic [DATA_BITS-1:0]          gnt_wdata;
    logic [CHANNELS*DATA_BITS-1:0] rdata_q;
    logic [DATA_BITS-1:0]          mem_q [2**ADDR_BITS];

    // Requester r: even = read of channel r/2, odd = write of channel r/2.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign req_valid[2*c]   = read_valid[c];
        assign req_valid[2*c+1] = write_valid[c];
        assign read_ready[c]    = req_ready[2*c];
        assign write_ready[c]   = req_ready[2*c+1];
    end

    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= REQS) begin
            sum = sum - REQS;
        end
        return PTR_W'(sum);
    endfunction

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < REQS; i++) begin
            if (!gnt_vld && req_elig[rr_index(ptr_q, i)]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_index(ptr_q, i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_idx == PTR_W'(REQS - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_comb begin
        gnt_addr  = '0;
        gnt_wdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (gnt_idx == PTR_W'(2*c)) begin
                gnt_addr = read_address[c*ADDR_BITS +: ADDR_BITS];
            end else if (gnt_idx == PTR_W'(2*c+1)) begin
                gnt_addr  = write_address[c*ADDR_BITS +: ADDR_BITS];
                gnt_wdata = write_data[c*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    for (genvar r = 0; r < REQS; r++) begin : g_req
        req_state_t state_q;
        logic [3:0] wait_q;
        logic       ready_q;
        logic       hit;

        assign hit          = gnt_vld && (gnt_idx == PTR_W'(r));
        assign req_elig[r]  = (state_q == ST_PENDING) && req_valid[r];
        assign req_ready[r] = ready_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                wait_q  <= '0;
                ready_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (req_valid[r]) begin
                            state_q <= ST_PENDING;
                        end
                    end
                    ST_PENDING: begin
                        if (!req_valid[r]) begin
                            state_q <= ST_IDLE;
                        end else if (hit) begin
                            if (LATENCY == 1) begin
                                state_q <= ST_RESPOND;
                                ready_q <= 1'b1;
                            end else begin
                                state_q <= ST_WAIT;
                                wait_q  <= WAIT_INIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        // Counter reaches zero on this edge.
                        if (wait_q == 4'd1) begin
                            state_q <= ST_RESPOND;
                            ready_q <= 1'b1;
                            wait_q  <= '0;
                        end else begin
                            wait_q <= wait_q - 4'd1;
                        end
                    end
                    default: begin
                        if (!req_valid[r]) begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // Storage has no reset so contents survive it.
    always_ff @(posedge clk) begin
        if (gnt_vld && gnt_idx[0]) begin
            mem_q[gnt_addr] <= gnt_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (gnt_vld && (gnt_idx == PTR_W'(2*c))) begin
                    rdata_q[c*DATA_BITS +: DATA_BITS] <= mem_q[gnt_addr];
                end
            end
        end
    end

    assign read_data = rdata_q;

`ifdef MEM_RESP_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (gnt_vld) begin
            if (gnt_idx[0]) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign read_count  = rd_cnt_q;
    assign write_count = wr_cnt_q;
`else
    // Grant counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Synthesizable multi-channel memory responder: the device end of the GPU's data/program memory request protocol. Each channel presents independent read and write requests using the valid/ready handshake driven by the GPU memory controller. The block serializes those requests onto one single-port storage array with round-robin arbitration, then answers after a configurable latency. It replaces the behavioural memory model in benches and serves as the on-chip memory in FPGA builds.

## Interface
- ADDR_BITS, 8: address width; array depth 2**ADDR_BITS words.
- DATA_BITS, 8: word width.
- CHANNELS, 4: number of request channels.
- LATENCY, 1: cycles from grant to ready; legal range 1..15.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all control state.
- read_valid  in  CHANNELS  per-channel read request.
- read_address  in  CHANNELS*ADDR_BITS  channel c at bits [c*ADDR_BITS +: ADDR_BITS].
- read_ready  out  CHANNELS  read response valid; reset 0.
- read_data  out  CHANNELS*DATA_BITS  read response word; reset 0.
- write_valid  in  CHANNELS  per-channel write request.
- write_address  in  CHANNELS*ADDR_BITS  write address, same packing.
- write_data  in  CHANNELS*DATA_BITS  write word.
- write_ready  out  CHANNELS  write acknowledge; reset 0.
- read_count, write_count  out  32 each  present only with MEM_RESP_STATS_EN; reset 0.

## Operation
- 2*CHANNELS requesters, ordered ch0 read, ch0 write, ch1 read, ch1 write, and so on. Each requester has its own FSM: IDLE, PENDING, WAIT, RESPOND.
- IDLE: valid sampled high -> PENDING. There is no combinational path from valid to grant.
- PENDING: the requester is eligible for arbitration. If valid is sampled low here, the request is dropped, no array access occurs, and the FSM returns to IDLE.
- Arbiter grants at most one PENDING requester per cycle, round-robin.
  - Pointer resets to requester 0.
  - After granting k, the pointer becomes (k+1) mod 2*CHANNELS.
  - With no grant, the pointer holds.
- Grant edge, read: the addressed word is captured into that channel's read_data register.
- Grant edge, write: write_data is written to write_address.
- Address and data are sampled only at the grant edge. The initiator holds them stable while valid is high.
- Ordering: grants are applied in order, so a read granted after a write to the same address returns the new data.
- After grant: LATENCY==1 -> RESPOND; otherwise -> WAIT with counter LATENCY-1. WAIT decrements each cycle and moves to RESPOND when the counter reaches 0.
- RESPOND: ready is high and read_data is held stable.
  - Valid sampled low -> IDLE, and ready drops on the following cycle (four-phase handshake).
  - A valid that stays high keeps ready high; the same request is never re-serviced.
- A channel's read and write FSMs are independent; both may be in flight at once.
- Storage array has no reset. Contents survive reset and are loadable by bench hierarchical access.
- read_data is not cleared when ready drops; it holds until the next read grant on that channel.
- Reset, including mid-transaction:
  - All FSMs return to IDLE; ready outputs go 0 and read_data goes 0.
  - Arbiter pointer goes to 0 and counters go 0.
  - A write already granted stays in the array; a write not yet granted is lost.

## Timing
- Uncontended: valid high in cycle 0 -> PENDING after edge 1 -> granted in cycle 1 -> ready high in cycle 1+LATENCY. Valid-to-ready is LATENCY+1 cycles.
- With N requesters contending, the worst-case extra wait is 2*CHANNELS-1 cycles.
- Throughput: one array access per cycle.
- Minimum per-requester transaction (valid to next acceptance) is LATENCY+3 cycles with immediate valid drop.
- ready is registered; read_data changes only at grant edges or reset.

## Configuration
- MEM_RESP_STATS_EN defined:
  - read_count and write_count ports exist.
  - Each increments by 1 per read or write grant and wraps at 2**32.
- Not defined:
  - The ports and counter logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset preload: array holds 0..7 at addresses 0..7 and LATENCY=1; ch0 reads address 3 -> read_ready high 2 cycles after valid, read_data=3, ready stays high until valid drops, then low 1 cycle later.
- Write-then-read, ch1: write 0x5A to address 0x20, ack seen, then read address 0x20 -> 0x5A. Same-cycle ch0 write 9 and ch0 read of the same address -> read granted first returns old data (pointer at 0).
- Contention: all 4 channels read addresses 0..3 in the same cycle -> grants in order ch0..ch3 on consecutive cycles; readies rise in cycles 2, 3, 4, 5 with data 0..3.
- LATENCY=4: single read -> ready in cycle 5; valid dropped while PENDING (behind a contender) -> no ready and no access counted.
- Reset asserted while a channel is in WAIT -> all readies 0 and read_data 0 immediately. A write granted before reset reads back correctly afterward.
- With MEM_RESP_STATS_EN: running the 2x2 matmul kernel (A=B=[1,2,3,4]) -> C at addresses 8..11 = 7,10,15,22; write_count=4, read_count=16.
